// File: rtl/cordic_ci_master.sv
// Purpose: issues streamed fp32 operands to the multicycle CORDIC custom instruction and returns results.
// Latency: 11 cycles accept-to-result nominally; a timeout abort returns an error result after TIMEOUT+3.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in HOLD until out_ready.
module cordic_ci_master #(
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             ci_clk_en,
  output logic             ci_aclr,
  output logic             ci_start,
  output logic [31:0]      ci_dataa,
  input  logic [31:0]      ci_result,
  input  logic             ci_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int WCW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_HOLD,
    S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      dataa_q, dataa_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Next-state and datapath updates; done is only honoured in WAIT and beats the timeout.
  always_comb begin
    state_d    = state_q;
    dataa_d    = dataa_q;
    wcnt_d     = wcnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dataa_d = in_data;
          state_d = S_START;
        end
      end
      S_START: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + WCW'(1);
        if (ci_done) begin
          out_data_d = ci_result;
          out_err_d  = 1'b0;
          if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
          state_d = S_HOLD;
        end else if (wcnt_q == WAIT_LAST) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          state_d    = S_ABORT;
        end
      end
      S_ABORT: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q    <= S_IDLE;
      dataa_q    <= '0;
      wcnt_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      dataa_q    <= dataa_d;
      wcnt_q     <= wcnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      op_count_q <= op_count_d;
    end
  end

  // Responder enable only while it should be iterating, so it cannot raise done elsewhere.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !aclr;
    ci_start  = (state_q == S_START);
    ci_clk_en = (state_q == S_START) || (state_q == S_WAIT);
    ci_aclr   = aclr || (state_q == S_ABORT);
    out_valid = (state_q == S_HOLD);
  end

  assign ci_dataa = dataa_q;
  assign out_data = out_data_q;
  assign out_err  = out_err_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_cordic_ci_master.sv
// Directed bench for cordic_ci_master with a behavioural CORDIC responder.
// Responder index starts at 0 the cycle after start and advances 2 per enabled cycle.
// Done is raised when the index equals 16, unless the never-done mode is selected.
module tb_cordic_ci_master;

  localparam int TIMEOUT = 31;
  localparam int CNT_W   = 4;
  localparam logic [31:0] RES = 32'h3F60A8B6;

  logic             clock = 1'b0;
  logic             aclr;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             ci_clk_en;
  logic             ci_aclr;
  logic             ci_start;
  logic [31:0]      ci_dataa;
  logic [31:0]      ci_result;
  logic             ci_done;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [4:0] idx = 5'd0;
  logic       never_done;
  logic       spur_done;

  cordic_ci_master #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .aclr(aclr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ci_clk_en(ci_clk_en), .ci_aclr(ci_aclr), .ci_start(ci_start),
    .ci_dataa(ci_dataa), .ci_result(ci_result), .ci_done(ci_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .op_count(op_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Responder model
  always @(posedge clock) begin
    if (ci_aclr) idx <= 5'd0;
    else if (ci_clk_en) idx <= ci_start ? 5'd0 : idx + 5'd2;
  end
  assign ci_done   = ((idx == 5'd16) && !never_done) || spur_done;
  assign ci_result = RES;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (ci_aclr !== 1'b1) begin failures++; $display("FAIL reset_ci_aclr got=%b exp=1", ci_aclr); end
    checks++; if ({ci_clk_en, ci_start, out_valid, out_err} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {ci_clk_en, ci_start, out_valid, out_err}); end
    checks++; if ({ci_dataa, out_data} !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {ci_dataa, out_data}); end
    checks++; if (op_count !== 4'h0) begin failures++; $display("FAIL reset_op_count got=%h exp=0", op_count); end
    aclr = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_nominal();
    int early;
    in_data  = 32'h3F000000;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL nom_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if ({ci_start, ci_clk_en} !== 2'b11) begin failures++; $display("FAIL nom_start got=%b exp=11", {ci_start, ci_clk_en}); end
    checks++; if (ci_dataa !== 32'h3F000000) begin failures++; $display("FAIL nom_dataa got=%h exp=3f000000", ci_dataa); end
    early = 0;
    for (int c = 2; c <= 10; c++) begin
      step();
      if (out_valid !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL nom_early_valid got=%0d exp=0", early); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL nom_valid_t11 got=%b exp=1", out_valid); end
    checks++; if (out_data !== RES) begin failures++; $display("FAIL nom_data got=%h exp=%h", out_data, RES); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL nom_err got=%b exp=0", out_err); end
    checks++; if (op_count !== 4'd1) begin failures++; $display("FAIL nom_op_count got=%h exp=1", op_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL nom_release got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_backpressure();
    int bad;
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 2; c <= 11; c++) step();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== RES || in_ready !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold_stable got=%0d bad cycles exp=0", bad); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_still_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL bp_idle got=%b exp=01", {out_valid, in_ready}); end
    in_data  = 32'h40000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (ci_start !== 1'b1 || ci_dataa !== 32'h40000000) begin failures++; $display("FAIL bp_next_accept got=%b/%h exp=1/40000000", ci_start, ci_dataa); end
    for (int c = 2; c <= 11; c++) step();
    checks++; if (out_valid !== 1'b1 || op_count !== 4'd3) begin failures++; $display("FAIL bp_second_result got=%b/%h exp=1/3", out_valid, op_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    never_done = 1'b1;
    in_data  = 32'h3E800000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 2; c <= 32; c++) step();
    checks++; if ({ci_aclr, out_valid} !== 2'b00) begin failures++; $display("FAIL to_t32 got=%b exp=00", {ci_aclr, out_valid}); end
    step();
    checks++; if ({ci_aclr, ci_clk_en, out_valid} !== 3'b100) begin failures++; $display("FAIL to_abort got=%b exp=100", {ci_aclr, ci_clk_en, out_valid}); end
    step();
    checks++; if ({ci_aclr, out_valid, out_err} !== 3'b011) begin failures++; $display("FAIL to_result got=%b exp=011", {ci_aclr, out_valid, out_err}); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL to_data got=%h exp=0", out_data); end
    checks++; if (op_count !== 4'd3) begin failures++; $display("FAIL to_op_count got=%h exp=3", op_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    never_done = 1'b0;
  endtask

  task automatic test_spurious();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL spur_idle_state got=%b exp=10", {in_ready, out_valid}); end
    checks++; if (op_count !== 4'd3 || out_data !== 32'h0) begin failures++; $display("FAIL spur_idle_regs got=%h/%h exp=3/0", op_count, out_data); end
    in_data  = 32'h3F000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 2; c <= 11; c++) step();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || op_count !== 4'd4 || out_data !== RES) begin failures++; $display("FAIL spur_hold got=%b/%h/%h exp=1/4/%h", out_valid, op_count, out_data, RES); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_data  = 32'h3F000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    aclr = 1'b1;
    #1;
    checks++; if (ci_aclr !== 1'b1) begin failures++; $display("FAIL rm_ci_aclr got=%b exp=1", ci_aclr); end
    step();
    checks++; if ({in_ready, ci_clk_en, ci_start, out_valid, out_err} !== 5'b0) begin failures++; $display("FAIL rm_ctrl got=%b exp=00000", {in_ready, ci_clk_en, ci_start, out_valid, out_err}); end
    checks++; if (ci_dataa !== 32'h0 || out_data !== 32'h0 || op_count !== 4'd0) begin failures++; $display("FAIL rm_regs got=%h/%h/%h exp=0/0/0", ci_dataa, out_data, op_count); end
    aclr = 1'b0;
    #1;
    in_data  = 32'h3F000000;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int c = 2; c <= 10; c++) step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_t10 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== RES || op_count !== 4'd1) begin failures++; $display("FAIL rm_result got=%b/%h/%h exp=1/%h/1", out_valid, out_data, op_count, RES); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc[17];
    int n;
    int gaps_bad;
    n = 0;
    in_data   = 32'h3F000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && n < 17; c++) begin
      if (in_ready) begin
        acc[n] = cyc;
        n++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (n !== 17) begin failures++; $display("FAIL b2b_accepts got=%0d exp=17", n); end
    gaps_bad = 0;
    for (int i = 1; i < n; i++) if (acc[i] - acc[i-1] != 12) gaps_bad++;
    checks++; if (gaps_bad !== 0) begin failures++; $display("FAIL b2b_spacing got=%0d bad gaps exp=0", gaps_bad); end
    for (int c = 2; c <= 12; c++) step();
    out_ready = 1'b0;
    checks++; if (op_count !== 4'hF) begin failures++; $display("FAIL b2b_saturate got=%h exp=f", op_count); end
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL b2b_end_idle got=%b exp=01", {out_valid, in_ready}); end
  endtask

  initial begin
    aclr       = 1'b1;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_ready  = 1'b0;
    never_done = 1'b0;
    spur_done  = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
